// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the scanned 7-segment display.
//   sel_e   : source-select encoding for the word shown on the display.
//   SEG_HEX : active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F,
//             indexed by the nibble value.
package seg_pkg;

    typedef enum logic [1:0] {
        SEL_LED    = 2'd0,
        SEL_ALL    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JMP    = 2'd3
    } sel_e;

    // Listed from entry 15 (F) down to entry 0 so SEG_HEX[n] is glyph n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to 7-segment decoder.
//   nibble : 4-bit hex value to show
//   seg_n  : active-low segments {g,f,e,d,c,b,a}
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 8-digit hex display driver.
//   clk          : system clock
//   clr_n        : asynchronous active-low reset
//   Leddata      : CPU LED/result word          (sel = 0)
//   Count_all    : total instruction count      (sel = 1)
//   Count_branch : branch count                 (sel = 2)
//   Count_jmp    : jump count                   (sel = 3)
//   sel          : source select, captured once per frame
//   blank_lz     : leading-zero blanking enable, used live
//   an           : active-low digit enables, bit k = nibble k
//   seg          : active-low segments {dp,g,f,e,d,c,b,a}
// A prescaler produces one tick every SCAN_DIV clocks; each tick moves to
// the next digit. The source word is captured only when the scan wraps
// from digit 7 back to digit 0, so every frame shows one coherent word.
// The decimal point marks the digit whose index equals the captured sel.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [31:0] Leddata,
    input  logic [31:0] Count_all,
    input  logic [31:0] Count_branch,
    input  logic [31:0] Count_jmp,
    input  logic [1:0]  sel,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int              PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PCNT_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [1:0]    snap_sel_q, snap_sel_d;   // sel captured with the snapshot
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          tick;
    logic          wrap;
    logic          blank;
    logic [31:0]   src_word;
    logic [3:0]    cur_nib;
    logic [6:0]    hex_seg;

    hex7seg u_hex7seg (
        .nibble (cur_nib),
        .seg_n  (hex_seg)
    );

    always_comb begin
        src_word = Leddata;
        case (sel_e'(sel))
            SEL_LED:    src_word = Leddata;
            SEL_ALL:    src_word = Count_all;
            SEL_BRANCH: src_word = Count_branch;
            SEL_JMP:    src_word = Count_jmp;
            default:    src_word = Leddata;
        endcase
    end

    always_comb begin
        tick       = (pcnt_q == PCNT_MAX);
        wrap       = tick && (idx_q == 3'd7);
        pcnt_d     = tick ? '0 : pcnt_q + PW'(1);
        idx_d      = tick ? idx_q + 3'd1 : idx_q;
        snap_d     = wrap ? src_word : snap_q;
        snap_sel_d = wrap ? sel : snap_sel_q;

        cur_nib    = snap_q[{idx_q, 2'b00} +: 4];
        // Digit k is a leading zero when nibbles k..7 are all zero, i.e.
        // the snapshot shifted down by 4*k is zero. Digit 0 always shows.
        blank      = blank_lz && (idx_q != 3'd0) &&
                     ((snap_q >> {idx_q, 2'b00}) == 32'd0);

        an_d       = blank ? 8'hFF : ~(8'b1 << idx_q);
        seg_d      = blank ? 8'hFF :
                     {(idx_q != {1'b0, snap_sel_q}), hex_seg};
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pcnt_q     <= '0;
            idx_q      <= 3'd0;
            snap_q     <= 32'd0;
            snap_sel_q <= 2'd0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            snap_sel_q <= snap_sel_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port clr_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Leddata  input  32  CPU LED/result word.
REQ-005 SHALL have port Count_all  input  32  total instruction count.
REQ-006 SHALL have port Count_branch  input  32  branch count.
REQ-007 SHALL have port Count_jmp  input  32  jump count.
REQ-008 SHALL have port sel  input  2  source select: 0 Leddata, 1 Count_all, 2 Count_branch, 3 Count_jmp.
REQ-009 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port an  output  8  digit enables, active-low; bit k drives digit k, where digit 0 is the least-significant nibble.
REQ-011 SHALL have port seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-012 SHALL count prescaler pcnt 0..SCAN_DIV-1 and wrap; tick = (pcnt == SCAN_DIV-1).
REQ-013 SHALL advance 3-bit digit index idx by one on tick, wrapping 7 -> 0.
REQ-014 SHALL, on a tick that wraps idx 7 -> 0, load a 32-bit snapshot with the word chosen by sel in that same cycle and register sel as sel_q.
REQ-015 SHALL ignore input and sel changes between wraps; the displayed frame is always one coherent word.
REQ-016 SHALL register an and seg; they reflect the idx/snapshot values from the previous cycle (1-cycle latency).
REQ-017 SHALL drive an = ~(8'b1 << idx) when the digit is not blanked, and an = 8'hFF when it is blanked.
REQ-018 SHALL drive seg[6:0] with the hex pattern of snapshot nibble idx (0-F, including A b C d E F glyphs).
REQ-019 SHALL light dp (seg[7] = 0) only when idx == sel_q; otherwise seg[7] = 1.
REQ-020 SHALL, when blank_lz = 1, blank digit k (k >= 1) if snapshot nibbles k..7 are all zero; digit 0 is never blanked; blank_lz is sampled live, not snapshotted.
REQ-021 SHALL set seg = 8'hFF whenever the active digit is blanked.

Reset
REQ-022 SHALL, while clr_n = 0: pcnt = 0, idx = 0, snapshot = 0, sel_q = 0, an = 8'hFF, seg = 8'hFF.
REQ-023 SHALL take effect asynchronously on assertion, including mid-frame; the partial frame is discarded.
REQ-024 SHALL, on the first edge after clr_n deasserts, output an = 8'hFE and seg = 8'h40 (digit 0 shows "0" with dp lit); the snapshot stays 0 until the first 7 -> 0 wrap.

Structure
REQ-025 SHALL place the 16-entry hex-to-segment pattern constants and the sel encoding constants in shared package seg_pkg.
REQ-026 SHALL implement the nibble-to-segment decode as combinational sub-module hex7seg (4-bit in, 7-bit out).
REQ-027 SHALL size pcnt as $clog2(SCAN_DIV) bits; no other width adaptation.

Verification (SCAN_DIV = 4)
REQ-028 Reset release -> an = FE, seg = 40 on the first edge; idx 1 enables an = FD after 4 clocks.
REQ-029 Leddata = 32'h1234ABCD, sel = 0, wait one full wrap -> digits 0..7 show D,C,B,A,4,3,2,1; digit 0 seg = 8'h21 (dp lit).
REQ-030 Mid-frame change of Leddata from 32'h1111_1111 to 32'h2222_2222 -> the current frame shows all 1s and the next frame shows all 2s; no mixed frame.
REQ-031 Count_jmp = 32'h0000_00F0, sel = 3, blank_lz = 1 -> only an bits 0 and 1 go low (0, F); digit 3 is blanked and dp is suppressed; with blank_lz = 0, digit 3 shows "0" with dp lit.
REQ-032 clr_n pulsed low while idx = 5 -> an = FF and seg = FF immediately (asynchronous), then the sequence restarts per REQ-024.
REQ-033 sel = 2 with Count_branch = 0 and blank_lz = 1 -> only digit 0 shows "0"; dp is off because sel_q = 2 falls on a blanked digit.
